// File: rtl/bpred_gshare_if.sv
// Fetch/resolve-side bus of the gshare branch predictor.
// The master drives lookup and resolve traffic; the slave is the predictor.
interface bpred_gshare_if #(
  parameter int HIST_BITS = 8
);
  logic [31:0]          i_addr;
  logic [31:0]          i_data;
  logic                 pred_valid;
  logic                 pred_taken;
  logic [HIST_BITS-1:0] pred_hist;
  logic [31:0]          b_addr;
  logic [31:0]          b_data;
  logic                 upd_valid;
  logic                 upd_taken;
  logic [HIST_BITS-1:0] upd_hist;
  logic                 ready;
  logic [31:0]          lookup_cnt;
  logic [31:0]          correct_cnt;

  modport master (
    output i_addr, i_data, b_addr, b_data, upd_valid, upd_taken, upd_hist,
    input  pred_valid, pred_taken, pred_hist, ready, lookup_cnt, correct_cnt
  );
  modport slave (
    input  i_addr, i_data, b_addr, b_data, upd_valid, upd_taken, upd_hist,
    output pred_valid, pred_taken, pred_hist, ready, lookup_cnt, correct_cnt
  );
endinterface

// File: rtl/bpred_gshare.sv
// Bimodal/gshare saturating-counter branch predictor with post-reset table sweep.
// Define BPRED_STATS_EN to build the lookup/correct-prediction counters.
module bpred_gshare #(
  parameter int CNT_BITS  = 2,
  parameter int IDX_BITS  = 10,
  parameter int HIST_BITS = 8,
  parameter int MODE      = 1,
  parameter int INIT_VAL  = 1
) (
  input  logic           clk,
  input  logic           rst,
  bpred_gshare_if.slave  bp
);
  localparam int ENTRIES = 2**IDX_BITS;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                 state;
  logic [IDX_BITS-1:0]    clr_idx;
  logic [HIST_BITS-1:0]   ghr;
  logic [HIST_BITS-1:0]   ghr_nx;
  logic                   ready_q;
  logic [CNT_BITS-1:0]    tbl [ENTRIES];
  logic [IDX_BITS-1:0]    i_idx, u_idx;
  logic [CNT_BITS-1:0]    u_cnt, u_next;
  logic                   upd_acc;
  logic                   unused_ok;

  function automatic logic is_br(input logic [31:0] d);
    return (d[31:26] == 6'b000001) || (d[31:28] == 4'b0001);
  endfunction

  function automatic logic [IDX_BITS-1:0] mk_idx(input logic [31:0] a,
                                                 input logic [HIST_BITS-1:0] h);
    logic [IDX_BITS-1:0] hx;
    hx = '0;
    hx[HIST_BITS-1:0] = h;
    return (MODE == 1) ? (a[IDX_BITS+1:2] ^ hx) : a[IDX_BITS+1:2];
  endfunction

  assign unused_ok = ^{bp.i_addr, bp.i_data, bp.b_addr, bp.b_data};

  assign i_idx   = mk_idx(bp.i_addr, ghr);
  assign u_idx   = mk_idx(bp.b_addr, bp.upd_hist);
  assign u_cnt   = tbl[u_idx];
  assign upd_acc = ready_q && bp.upd_valid && is_br(bp.b_data);

  always_comb begin
    u_next = u_cnt;
    if (bp.upd_taken) begin
      if (u_cnt != {CNT_BITS{1'b1}}) u_next = u_cnt + 1'b1;
    end else begin
      if (u_cnt != '0) u_next = u_cnt - 1'b1;
    end
  end

  generate
    if (HIST_BITS == 1) begin : g_h1
      assign ghr_nx = bp.upd_taken;
    end else begin : g_hn
      assign ghr_nx = {ghr[HIST_BITS-2:0], bp.upd_taken};
    end
  endgenerate

  // Lookup reads the table as it stands this cycle: no update bypass.
  assign bp.pred_valid = ready_q && is_br(bp.i_data);
  assign bp.pred_taken = bp.pred_valid && tbl[i_idx][CNT_BITS-1];
  assign bp.pred_hist  = ghr;
  assign bp.ready      = ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ghr     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == '1) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: if (upd_acc) ghr <= ghr_nx;
        default: state <= CLEAR;
      endcase
    end
  end

  // Table has no reset; the sweep owns the write port until RUN.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      tbl[clr_idx] <= CNT_BITS'(INIT_VAL);
    else if (upd_acc)
      tbl[u_idx] <= u_next;
  end

`ifdef BPRED_STATS_EN
  logic [31:0] lookup_q, correct_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookup_q  <= '0;
      correct_q <= '0;
    end else begin
      if (bp.pred_valid && lookup_q != '1) lookup_q <= lookup_q + 1'b1;
      if (upd_acc && (u_cnt[CNT_BITS-1] == bp.upd_taken) && correct_q != '1)
        correct_q <= correct_q + 1'b1;
    end
  end

  assign bp.lookup_cnt  = lookup_q;
  assign bp.correct_cnt = correct_q;
`else
  assign bp.lookup_cnt  = '0;
  assign bp.correct_cnt = '0;
`endif
endmodule

// File: tb/tb_bpred_gshare.sv
// Scoreboard bench: a bimodal instance and a gshare instance share clock and reset.
module tb_bpred_gshare;
  localparam logic [31:0] BD = 32'h0400_0000;  // opcode 000001
  localparam logic [31:0] BS = 32'h1000_0000;  // top nibble 0001
  localparam logic [31:0] NB = 32'h2000_0000;
  localparam int RDY0 = 0, PV0 = 1, PT0 = 2, RDY1 = 3, PV1 = 4, PT1 = 5, PH1 = 6, LK1 = 7, CR1 = 8;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  logic clk, rst;
  int   n_chk, n_err;
  exp_t sb[$];
  int   m1 [int];
  logic [7:0] mghr;
  int   exp_lk, exp_cr;

  bpred_gshare_if #(.HIST_BITS(8)) b0 ();
  bpred_gshare_if #(.HIST_BITS(8)) b1 ();

  bpred_gshare #(.MODE(0)) dut0 (.clk(clk), .rst(rst), .bp(b0.slave));
  bpred_gshare #(.MODE(1)) dut1 (.clk(clk), .rst(rst), .bp(b1.slave));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int sig);
    case (sig)
      RDY0:    return {31'b0, b0.ready};
      PV0:     return {31'b0, b0.pred_valid};
      PT0:     return {31'b0, b0.pred_taken};
      RDY1:    return {31'b0, b1.ready};
      PV1:     return {31'b0, b1.pred_valid};
      PT1:     return {31'b0, b1.pred_taken};
      PH1:     return {24'b0, b1.pred_hist};
      LK1:     return b1.lookup_cnt;
      CR1:     return b1.correct_cnt;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sig = sig; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sig), e.exp);
    end
  endtask

  function automatic bit isbr(input logic [31:0] d);
    return (d[31:26] == 6'b000001) || (d[31:28] == 4'b0001);
  endfunction

  function automatic int midx1(input logic [31:0] a, input logic [7:0] h);
    logic [9:0] pc;
    pc = a[11:2];
    return int'(pc ^ {2'b00, h});
  endfunction

  function automatic int mcnt(input int i);
    return m1.exists(i) ? m1[i] : 1;
  endfunction

  task automatic up0(input logic taken);
    b0.upd_taken = taken;
    b0.upd_valid = 1'b1;
    @(posedge clk); #1;
    b0.upd_valid = 1'b0;
  endtask

  task automatic up1(input logic [31:0] a, input logic [31:0] d, input logic taken);
    int idx, c;
    b1.b_addr = a; b1.b_data = d; b1.upd_taken = taken; b1.upd_hist = mghr;
    b1.upd_valid = 1'b1;
    @(posedge clk); #1;
    b1.upd_valid = 1'b0;
    if (isbr(d)) begin
      idx = midx1(a, mghr);
      c = mcnt(idx);
      if ((c >= 2) == taken) exp_cr++;
      c = taken ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
      m1[idx] = c;
      mghr = {mghr[6:0], taken};
    end
  endtask

  task automatic lk1(input string tag, input logic [31:0] a, input logic [31:0] d);
    bit v;
    v = isbr(d);
    b1.i_addr = a; b1.i_data = d;
    push({tag, "_v"}, PV1, {31'b0, v});
    push({tag, "_t"}, PT1, {31'b0, v && (mcnt(midx1(a, mghr)) >= 2)});
    push({tag, "_h"}, PH1, {24'b0, mghr});
    sample();
    @(posedge clk); #1;
    if (v) exp_lk++;
    b1.i_data = 32'h0;
  endtask

  initial begin
    int cnt;
    logic [31:0] d;
    clk = 0; rst = 1; n_chk = 0; n_err = 0;
    mghr = '0; exp_lk = 0; exp_cr = 0;
    b0.i_addr = 32'h0001_0044; b0.i_data = BD; b0.b_addr = '0; b0.b_data = '0;
    b0.upd_valid = 0; b0.upd_taken = 0; b0.upd_hist = '0;
    b1.i_addr = '0; b1.i_data = BD; b1.b_addr = '0; b1.b_data = '0;
    b1.upd_valid = 0; b1.upd_taken = 0; b1.upd_hist = '0;

    repeat (3) @(posedge clk); #1;
    push("rst_ready0", RDY0, 0); push("rst_pv0", PV0, 0); push("rst_pt0", PT0, 0);
    push("rst_ready1", RDY1, 0); push("rst_hist1", PH1, 0);
    push("rst_lk1", LK1, 0); push("rst_cr1", CR1, 0);
    sample();
    @(posedge clk); #1 rst = 0;

    // Lookups during the sweep must stay invalid; then reset mid-sweep.
    repeat (500) @(posedge clk); #1;
    push("sweep_ready0", RDY0, 0); push("sweep_pv0", PV0, 0); push("sweep_pt0", PT0, 0);
    push("sweep_pv1", PV1, 0);
    sample();
    @(posedge clk); #1 rst = 1;
    push("midrst_ready0", RDY0, 0);
    sample();
    b0.i_data = 32'h0; b1.i_data = 32'h0;
    @(posedge clk); #1 rst = 0;

    cnt = 0;
    while (cnt < 2000) begin
      @(negedge clk);
      if (b0.ready) break;
      cnt++;
    end
    chk("sweep_len", cnt, 1024);
    chk("sweep_ready1", {31'b0, b1.ready}, 1);
    @(posedge clk); #1;

    // Bimodal saturation at PC 0x00010044.
    b0.i_addr = 32'h0001_0044; b0.i_data = BD;
    b0.b_addr = 32'h0001_0044; b0.b_data = BD;
    push("bim_init_v", PV0, 1); push("bim_init_t", PT0, 0);
    sample(); @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      up0(k < 3);
      push($sformatf("bim_upd%0d", k), PT0, (k == 4) ? 0 : 1);
      sample(); @(posedge clk); #1;
    end
    b0.i_data = BS;
    push("bim_bs_v", PV0, 1); push("bim_bs_t", PT0, 0);
    sample(); @(posedge clk); #1;

    // Non-branch filter.
    b0.i_data = NB;
    push("nb_v", PV0, 0); push("nb_t", PT0, 0);
    sample(); @(posedge clk); #1;
    b0.b_data = NB;
    up0(1); up0(1);
    b0.i_data = BD; b0.b_data = BD;
    push("nb_upd_t", PT0, 0);
    sample(); @(posedge clk); #1;

    // Same-cycle lookup and update to counter=1.
    b0.upd_taken = 1; b0.upd_valid = 1;
    push("haz_same", PT0, 0);
    sample(); @(posedge clk); #1;
    b0.upd_valid = 0;
    push("haz_next", PT0, 1);
    sample(); @(posedge clk); #1;

    // Gshare history and aliasing.
    up1(32'h100, BD, 1); up1(32'h100, BD, 1); up1(32'h100, BD, 0);
    push("gs_ghr6", PH1, 8'h06); push("gs_pc0_t", PT1, 0);
    lk1("gs_pc0", 32'h0, BD);
    up1(32'h0, BD, 1);
    push("gs_e6_t", PT1, 1);
    lk1("gs_e6", 32'h2C, BD);
    push("gs_e0_t", PT1, 0);
    lk1("gs_e0", 32'h34, BD);
    up1(32'h0, NB, 1);
    push("gs_nb_ghr", PH1, 8'h0D);
    lk1("gs_nb", 32'h34, BD);
    lk1("gs_nbl", 32'h34, NB);

    // Random mix against the model.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 2))
        0:       d = BD;
        1:       d = 32'h1234_5678;
        default: d = NB;
      endcase
      if ($urandom_range(0, 1) == 1) up1({26'b0, 4'($urandom_range(0, 15)), 2'b00}, d, 1'($urandom_range(0, 1)));
      else lk1($sformatf("rnd%0d", k), {26'b0, 4'($urandom_range(0, 15)), 2'b00}, d);
    end

`ifdef BPRED_STATS_EN
    push("stat_lookup", LK1, exp_lk); push("stat_correct", CR1, exp_cr);
`else
    push("stat_lookup_off", LK1, 0); push("stat_correct_off", CR1, 0);
`endif
    sample(); @(posedge clk); #1;

    // Asynchronous reset drops ready without a clock edge.
    rst = 1; #1;
    chk("arst_ready0", {31'b0, b0.ready}, 0);
    chk("arst_ready1", {31'b0, b1.ready}, 0);
    chk("arst_hist1", {24'b0, b1.pred_hist}, 0);
    chk("arst_lk1", b1.lookup_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
